// File: rtl/hpm_trace_pkg.sv
// Shared types and helpers for the HPM tracer / window-delta slice.
// Holds the HPM vector type, delta FSM states and the masked-index search.
package hpm_trace_pkg;

  localparam int NUM_HPM   = 32;
  localparam int HPM_W     = 64;
  localparam int HPM_IDX_W = 5;

  typedef logic [NUM_HPM-1:0][HPM_W-1:0] hpm_vec_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } delta_state_e;

  typedef struct packed {
    logic                 found;
    logic [HPM_IDX_W-1:0] idx;
  } idx_search_t;

  // Lowest set mask bit strictly above idx; found=0 when none exists.
  function automatic idx_search_t next_set_idx(input logic [NUM_HPM-1:0] mask,
                                               input logic [HPM_IDX_W-1:0] idx);
    idx_search_t r;
    r = '0;
    for (int i = NUM_HPM - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(idx))) begin
        r.found = 1'b1;
        r.idx   = i[HPM_IDX_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/hpm_sat_delta.sv
// Modular 64-bit counter delta, clamped to an unsigned FEAT_W-bit result.
module hpm_sat_delta
  import hpm_trace_pkg::*;
#(
  parameter int unsigned FEAT_W = 16
) (
  input  logic [HPM_W-1:0]  cur_i,
  input  logic [HPM_W-1:0]  prev_i,
  output logic [FEAT_W-1:0] delta_o
);

  logic [HPM_W-1:0] diff;

  // Wrapping subtraction gives the true delta even across a counter rollover.
  assign diff = cur_i - prev_i;

  generate
    if (FEAT_W >= HPM_W) begin : g_full
      assign delta_o = diff[FEAT_W-1:0];
    end else begin : g_sat
      assign delta_o = (|diff[HPM_W-1:FEAT_W]) ? {FEAT_W{1'b1}} : diff[FEAT_W-1:0];
    end
  endgenerate

endmodule

// File: rtl/hpm_window_delta.sv
// Snapshots the HPM vector on each tracer window and streams saturated deltas.
// Optional threshold alarm enabled by defining HPM_DELTA_ALARM_EN.
module hpm_window_delta
  import hpm_trace_pkg::*;
#(
  parameter int unsigned        FEAT_W   = 16,
  parameter logic [NUM_HPM-1:0] CNT_MASK = 32'hFFFF_FFFF
) (
  input  logic                 clk_h,
  input  logic                 rst_h,
  input  logic                 enable_detect_i,
  input  hpm_vec_t             hpm_i,
  output logic                 feat_valid_o,
  input  logic                 feat_ready_i,
  output logic [HPM_IDX_W-1:0] feat_idx_o,
  output logic [FEAT_W-1:0]    feat_data_o,
  output logic                 feat_last_o,
  output logic                 end_detect_o,
  output logic                 busy_o,
  output logic                 overrun_o
`ifdef HPM_DELTA_ALARM_EN
  ,
  input  logic [FEAT_W-1:0]    thresh_i,
  output logic                 alarm_o
`endif
);

  delta_state_e         state_q, state_d;
  logic [HPM_IDX_W-1:0] idx_q, idx_d;
  hpm_vec_t             cur_q, cur_d;
  hpm_vec_t             prev_q, prev_d;
  logic                 overrun_q, overrun_d;

  idx_search_t          first_s, next_s;
  logic [FEAT_W-1:0]    delta;
  logic                 streaming;
  logic                 hs;

  assign first_s   = CNT_MASK[0] ? '{found: 1'b1, idx: '0} : next_set_idx(CNT_MASK, '0);
  assign next_s    = next_set_idx(CNT_MASK, idx_q);
  assign streaming = (state_q == STREAM);
  assign hs        = streaming && feat_ready_i;

  hpm_sat_delta #(
    .FEAT_W (FEAT_W)
  ) u_sat (
    .cur_i   (cur_q[idx_q]),
    .prev_i  (prev_q[idx_q]),
    .delta_o (delta)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cur_d     = cur_q;
    prev_d    = prev_q;
    overrun_d = overrun_q;
    case (state_q)
      IDLE: begin
        if (enable_detect_i) begin
          cur_d = hpm_i;
          if (first_s.found) begin
            idx_d   = first_s.idx;
            state_d = STREAM;
          end else begin
            state_d = DONE;
          end
        end
      end
      STREAM: begin
        if (enable_detect_i) overrun_d = 1'b1;
        if (hs) begin
          if (next_s.found) idx_d = next_s.idx;
          else              state_d = DONE;
        end
      end
      DONE: begin
        // A pulse coinciding with end_detect_o still lands while busy.
        if (enable_detect_i) overrun_d = 1'b1;
        prev_d  = cur_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_h or negedge rst_h) begin
    if (!rst_h) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cur_q     <= '0;
      prev_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cur_q     <= cur_d;
      prev_q    <= prev_d;
      overrun_q <= overrun_d;
    end
  end

  assign feat_valid_o = streaming;
  assign feat_idx_o   = streaming ? idx_q : '0;
  assign feat_data_o  = streaming ? delta : '0;
  assign feat_last_o  = streaming && !next_s.found;
  assign end_detect_o = (state_q == DONE);
  assign busy_o       = (state_q != IDLE);
  assign overrun_o    = overrun_q;

`ifdef HPM_DELTA_ALARM_EN
  logic alarm_q, alarm_d;

  always_comb begin
    alarm_d = alarm_q;
    if ((state_q == IDLE) && enable_detect_i) alarm_d = 1'b0;
    else if (hs && (feat_data_o > thresh_i))  alarm_d = 1'b1;
  end

  always_ff @(posedge clk_h or negedge rst_h) begin
    if (!rst_h) alarm_q <= 1'b0;
    else        alarm_q <= alarm_d;
  end

  assign alarm_o = alarm_q;
`endif

endmodule

// File: tb/tb_hpm_window_delta.sv
// Bench for hpm_window_delta: a full-mask and a sparse-mask instance share stimulus
// and are checked against a per-window reference built from the counter values.
module tb_hpm_window_delta;
  import hpm_trace_pkg::*;

  localparam int          FW     = 16;
  localparam logic [31:0] MASK_A = 32'hFFFF_FFFF;
  localparam logic [31:0] MASK_B = 32'h0000_8005;

  logic           clk_h = 1'b0;
  logic           rst_h = 1'b0;
  logic           en    = 1'b0;
  hpm_vec_t       hpm   = '0;
  logic           ready = 1'b1;
  logic [1:0]     valid, last, endp, busy, ovr;
  logic [4:0]     idx  [2];
  logic [FW-1:0]  data [2];
`ifdef HPM_DELTA_ALARM_EN
  logic [1:0]     alarm;
  logic [FW-1:0]  thresh = '1;
`endif

  always #5 clk_h = ~clk_h;

  hpm_window_delta #(.FEAT_W(FW), .CNT_MASK(MASK_A)) u_full (
    .clk_h(clk_h), .rst_h(rst_h), .enable_detect_i(en), .hpm_i(hpm),
    .feat_valid_o(valid[0]), .feat_ready_i(ready), .feat_idx_o(idx[0]),
    .feat_data_o(data[0]), .feat_last_o(last[0]), .end_detect_o(endp[0]),
    .busy_o(busy[0]), .overrun_o(ovr[0])
`ifdef HPM_DELTA_ALARM_EN
    , .thresh_i(thresh), .alarm_o(alarm[0])
`endif
  );

  hpm_window_delta #(.FEAT_W(FW), .CNT_MASK(MASK_B)) u_sparse (
    .clk_h(clk_h), .rst_h(rst_h), .enable_detect_i(en), .hpm_i(hpm),
    .feat_valid_o(valid[1]), .feat_ready_i(ready), .feat_idx_o(idx[1]),
    .feat_data_o(data[1]), .feat_last_o(last[1]), .end_detect_o(endp[1]),
    .busy_o(busy[1]), .overrun_o(ovr[1])
`ifdef HPM_DELTA_ALARM_EN
    , .thresh_i(thresh), .alarm_o(alarm[1])
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference state: previous snapshot and sticky overrun per instance
  logic [63:0]   prev_m [2][32];
  bit            ov_m   [2];
  logic [31:0]   mask_m [2];
  logic [FW-1:0] cap    [32];

  typedef struct {
    int            win;
    int            idx;
    logic [FW-1:0] exp;
  } vec_t;
  vec_t tbl [11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [FW-1:0] sat_ref(input logic [63:0] c, input logic [63:0] p);
    logic [63:0] d;
    d = c - p;
    if (d > ((64'd1 << FW) - 64'd1)) return '1;
    return d[FW-1:0];
  endfunction

  function automatic hpm_vec_t base_vec(input int off);
    hpm_vec_t v;
    for (int i = 0; i < 32; i++) v[i] = 64'(i * 10 + off);
    return v;
  endfunction

  task automatic chk_quiet(input int k, input string tag);
    chk({tag, "_valid"}, valid[k], 0);
    chk({tag, "_idx"},   idx[k],   0);
    chk({tag, "_data"},  data[k],  0);
    chk({tag, "_last"},  last[k],  0);
    chk({tag, "_end"},   endp[k],  0);
    chk({tag, "_busy"},  busy[k],  0);
    chk({tag, "_ovr"},   ovr[k],   0);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ov_m[k] = 0;
      for (int i = 0; i < 32; i++) prev_m[k][i] = '0;
    end
  endtask

  // rmode: 0 ready high, 1 ready pattern 1,0,0 repeating, 2 random ready
  task automatic run_window(input hpm_vec_t v, input int rmode, input bit poke);
    int            eidx  [2][32];
    logic [FW-1:0] edata [2][32];
    int            ecnt  [2];
    int            ptr   [2];
    int            end_c [2];
    bit            stall [2];
    logic [4:0]    pidx  [2];
    logic [FW-1:0] pdata [2];
    logic          plast [2];
    for (int i = 0; i < 32; i++) cap[i] = 'x;
    for (int k = 0; k < 2; k++) begin
      ecnt[k] = 0; ptr[k] = 0; end_c[k] = -1; stall[k] = 0;
      for (int i = 0; i < 32; i++) begin
        if (mask_m[k][i]) begin
          eidx[k][ecnt[k]]  = i;
          edata[k][ecnt[k]] = sat_ref(v[i], prev_m[k][i]);
          ecnt[k]++;
        end
      end
    end
    @(negedge clk_h);
    hpm = v; en = 1'b1;
    @(negedge clk_h);
    en = 1'b0; hpm = '0;
    for (int c = 1; c <= 300 && (end_c[0] < 0 || end_c[1] < 0); c++) begin
      case (rmode)
        0:       ready = 1'b1;
        1:       ready = ((c - 1) % 3 == 0);
        default: ready = 1'($urandom_range(0, 1));
      endcase
      en = poke && (c == 3 || c == 4);
      if (en) for (int i = 0; i < 32; i++) hpm[i] = {$urandom, $urandom};
      else    hpm = '0;
      for (int k = 0; k < 2; k++) begin
        if (end_c[k] < 0) begin
          if (stall[k]) begin
            chk("stall_idx",  idx[k],  pidx[k]);
            chk("stall_data", data[k], pdata[k]);
            chk("stall_last", last[k], plast[k]);
          end
          chk("busy", busy[k], 1);
          if (valid[k]) begin
            chk("end_early", endp[k], 0);
            if (ptr[k] < ecnt[k]) begin
              chk("word_idx",  idx[k],  eidx[k][ptr[k]]);
              chk("word_data", data[k], edata[k][ptr[k]]);
              chk("word_last", last[k], (ptr[k] == ecnt[k] - 1));
            end else begin
              chk("extra_word", ptr[k], ecnt[k] - 1);
            end
            stall[k] = !ready;
            pidx[k] = idx[k]; pdata[k] = data[k]; plast[k] = last[k];
            if (ready) begin
              if (k == 0) cap[idx[0]] = data[0];
              ptr[k]++;
            end
          end else begin
            stall[k] = 0;
            chk("end_pulse", endp[k], 1);
            chk("word_count", ptr[k], ecnt[k]);
            if (rmode == 0) chk("end_latency", c, 1 + ecnt[k]);
            end_c[k] = c;
          end
        end
      end
      @(negedge clk_h);
    end
    en = 1'b0; hpm = '0;
    for (int k = 0; k < 2; k++) begin
      if (end_c[k] < 0) chk("end_timeout", 0, 1);
      for (int i = 0; i < 32; i++) prev_m[k][i] = v[i];
      if (poke) ov_m[k] = 1;
    end
    @(negedge clk_h);
    for (int k = 0; k < 2; k++) begin
      chk("idle_busy",  busy[k],  0);
      chk("idle_valid", valid[k], 0);
      chk("idle_end",   endp[k],  0);
      chk("overrun",    ovr[k],   ov_m[k]);
    end
  endtask

  task automatic check_tbl(input int w);
    for (int j = 0; j < 11; j++)
      if (tbl[j].win == w) chk($sformatf("tbl_w%0d_idx%0d", w, tbl[j].idx), cap[tbl[j].idx], tbl[j].exp);
  endtask

  task automatic reset_mid_stream(input hpm_vec_t v);
    @(negedge clk_h);
    hpm = v; en = 1'b1;
    @(negedge clk_h);
    en = 1'b0; hpm = '0; ready = 1'b1;
    repeat (2) @(negedge clk_h);
    chk("pre_reset_valid", valid[0], 1);
    rst_h = 1'b0;
    #1;
    chk_quiet(0, "async_rst_full");
    chk_quiet(1, "async_rst_sparse");
    repeat (2) begin
      @(negedge clk_h);
      chk("rst_no_end0", endp[0], 0);
      chk("rst_no_end1", endp[1], 0);
    end
    rst_h = 1'b1;
    model_reset();
  endtask

  initial begin
    hpm_vec_t v;
    logic [63:0] p;
    mask_m[0] = MASK_A;
    mask_m[1] = MASK_B;
    tbl[0]  = '{1, 0,  16'd0};
    tbl[1]  = '{1, 5,  16'd50};
    tbl[2]  = '{1, 31, 16'd310};
    tbl[3]  = '{2, 3,  16'hFFFF};
    tbl[4]  = '{2, 5,  16'hFFFF};
    tbl[5]  = '{2, 7,  16'd0};
    tbl[6]  = '{3, 5,  16'h0020};
    tbl[7]  = '{3, 3,  16'hFFFF};
    tbl[8]  = '{3, 4,  16'd0};
    tbl[9]  = '{4, 9,  16'd97};
    tbl[10] = '{4, 0,  16'd7};

    model_reset();
    repeat (3) @(negedge clk_h);
    chk_quiet(0, "reset_full");
    chk_quiet(1, "reset_sparse");
    rst_h = 1'b1;

    v = base_vec(0);
    run_window(v, 0, 0);
    check_tbl(1);
    $display("window 1: absolute counts, ready high");

    v[3] = 64'h1_0000_0100;
    v[5] = 64'hFFFF_FFFF_FFFF_FFF0;
    run_window(v, 1, 0);
    check_tbl(2);
    $display("window 2: saturation, ready toggling");

    v = base_vec(0);
    v[5] = 64'h10;
    run_window(v, 0, 1);
    check_tbl(3);
    $display("window 3: wrap delta, enables mid-stream and at end pulse");

    reset_mid_stream(base_vec(3));
    $display("reset mid-stream");

    run_window(base_vec(7), 0, 0);
    check_tbl(4);
    $display("window 4: deltas relative to zero after reset");

    for (int w = 0; w < 20; w++) begin
      for (int i = 0; i < 32; i++) begin
        p = prev_m[0][i];
        case ($urandom_range(0, 4))
          0:       v[i] = p + 64'($urandom_range(0, 65535));
          1:       v[i] = p + {$urandom, $urandom};
          2:       v[i] = p - 64'($urandom_range(1, 1000));
          3:       v[i] = p + 64'd65535 + 64'($urandom_range(0, 1));
          default: v[i] = p;
        endcase
      end
      run_window(v, 2, 0);
      $display("random window %0d", w);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
